// File: rtl/decode_issue_queue.sv
// decode_issue_queue: in-order decode/issue queue with a register scoreboard.
// Fetched instructions are buffered in a DEPTH-entry FIFO. The head is decoded
// and, when free of register hazards, moved into a single issue register that
// drives the execute stage. Long ops (MULT/DIV/FPU) reserve their destination
// in a scoreboard until a writeback port reports completion.
//
// Ports:
//   iClk, iRst              clock, synchronous active-high reset
//   iInstrValid/oInstrReady fetch handshake, iInstruction payload
//   iFlush                  drop queued and staged instructions
//   oIssueValid/iIssueReady issue handshake
//   oOpcode..oOffset        registered decoded issue fields
//   iWbValid/iWbAddr        long-op completion, one 5-bit address per port
//   oCount                  queue occupancy (issue register excluded)
//   oHalted                 a HALT has issued; sticky until reset
module decode_issue_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned NUM_WB = 2
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iInstrValid,
    output logic                      oInstrReady,
    input  logic [31:0]               iInstruction,
    input  logic                      iFlush,
    output logic                      oIssueValid,
    input  logic                      iIssueReady,
    output logic [5:0]                oOpcode,
    output logic [4:0]                oAddrRead0,
    output logic                      oEnRead0,
    output logic [4:0]                oAddrRead1,
    output logic                      oEnRead1,
    output logic [4:0]                oAddrWrite,
    output logic                      oEnWrite,
    output logic                      oLongOp,
    output logic [25:0]               oOffset,
    input  logic [NUM_WB-1:0]         iWbValid,
    input  logic [5*NUM_WB-1:0]       iWbAddr,
    output logic [$clog2(DEPTH):0]    oCount,
    output logic                      oHalted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [5:0] OP_HALT = 6'h1F;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_sb;
    logic          r_halted;
    logic          r_valid;
    logic [5:0]    r_op;
    logic [4:0]    r_ar0;
    logic          r_er0;
    logic [4:0]    r_ar1;
    logic          r_er1;
    logic [4:0]    r_aw;
    logic          r_ew;
    logic          r_long;
    logic [25:0]   r_off;

    logic [31:0]   w_head;
    logic [5:0]    w_op;
    logic [4:0]    w_rd;
    logic [4:0]    w_rs1;
    logic [4:0]    w_rs2;
    logic [4:0]    w_ar0;
    logic          w_er0;
    logic [4:0]    w_ar1;
    logic          w_er1;
    logic [4:0]    w_aw;
    logic          w_ew;
    logic          w_long;
    logic          w_iss_wr;
    logic          w_hz;
    logic          w_halt_pending;
    logic          w_pop;
    logic          w_push;
    logic          w_hs;
    logic [31:0]   w_sb_next;

    assign w_head = r_mem[r_rd_ptr];
    assign w_op   = w_head[31:26];
    assign w_rd   = w_head[25:21];
    assign w_rs1  = w_head[20:16];
    assign w_rs2  = w_head[15:11];

    // Decode of the queue head into register-file controls
    always_comb begin
        w_ew  = 1'b1;
        w_aw  = w_rd;
        w_er0 = 1'b1;
        w_ar0 = w_rs1;
        w_er1 = 1'b1;
        w_ar1 = w_rs2;
        case (w_op)
            6'h0C, 6'h10, 6'h15, 6'h1F, 6'h20, 6'h24: w_ew = 1'b0;
            default: ;
        endcase
        case (w_op)
            6'h11, 6'h12: w_aw = 5'd1;
            default: ;
        endcase
        case (w_op)
            6'h03, 6'h0C, 6'h10, 6'h1F, 6'h20, 6'h25: w_er0 = 1'b0;
            default: ;
        endcase
        case (w_op)
            6'h02, 6'h24: w_ar0 = w_rd;
            6'h11, 6'h12: w_ar0 = 5'd1;
            default: ;
        endcase
        case (w_op)
            6'h02, 6'h03, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h10, 6'h11,
            6'h1C, 6'h1D, 6'h1E, 6'h1F, 6'h20, 6'h24, 6'h25: w_er1 = 1'b0;
            default: ;
        endcase
        case (w_op)
            6'h14, 6'h15: w_ar1 = w_rd;
            6'h12:        w_ar1 = 5'd0;
            default: ;
        endcase
    end

    assign w_long = (w_op >= 6'h16) && (w_op <= 6'h1E);

    // A long op still sitting in the issue register has not reached the
    // scoreboard yet, so its destination is checked directly.
    assign w_iss_wr = r_valid && r_long && r_ew && (r_aw != 5'd0);

    assign w_hz = (w_er0 && (w_ar0 != 5'd0) && (r_sb[w_ar0] || (w_iss_wr && (r_aw == w_ar0))))
               || (w_er1 && (w_ar1 != 5'd0) && (r_sb[w_ar1] || (w_iss_wr && (r_aw == w_ar1))))
               || (w_ew  && (w_aw  != 5'd0) && (r_sb[w_aw]  || (w_iss_wr && (r_aw == w_aw))));

    // Nothing may follow a staged HALT into the issue register
    assign w_halt_pending = r_valid && (r_op == OP_HALT);

    assign w_hs   = r_valid && iIssueReady;
    assign w_pop  = (r_count != CW'(0)) && !w_hz && !r_halted && !w_halt_pending
                 && (!r_valid || iIssueReady);
    assign oInstrReady = !r_halted && ((r_count < CW'(DEPTH)) || w_pop);
    assign w_push = iInstrValid && oInstrReady;

    // Scoreboard next state: writeback clears first, issue set wins
    always_comb begin
        w_sb_next = r_sb;
        for (int k = 0; k < int'(NUM_WB); k++) begin
            if (iWbValid[k]) w_sb_next[iWbAddr[5*k +: 5]] = 1'b0;
        end
        if (w_hs && !iFlush && r_long && r_ew && (r_aw != 5'd0)) w_sb_next[r_aw] = 1'b1;
    end

    // Queue storage
    always_ff @(posedge iClk) begin
        if (!iRst && !iFlush && w_push) r_mem[r_wr_ptr] <= iInstruction;
    end

    // Pointers, occupancy, issue register, scoreboard, halt flag
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_sb     <= '0;
            r_halted <= 1'b0;
            r_valid  <= 1'b0;
            r_op     <= '0;
            r_ar0    <= '0;
            r_er0    <= 1'b0;
            r_ar1    <= '0;
            r_er1    <= 1'b0;
            r_aw     <= '0;
            r_ew     <= 1'b0;
            r_long   <= 1'b0;
            r_off    <= '0;
        end else begin
            r_sb <= w_sb_next;
            if (iFlush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_valid  <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= AW'(r_wr_ptr + AW'(1));
                if (w_pop)  r_rd_ptr <= AW'(r_rd_ptr + AW'(1));
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: ;
                endcase
                if (w_pop) begin
                    r_valid <= 1'b1;
                    r_op    <= w_op;
                    r_ar0   <= w_ar0;
                    r_er0   <= w_er0;
                    r_ar1   <= w_ar1;
                    r_er1   <= w_er1;
                    r_aw    <= w_aw;
                    r_ew    <= w_ew;
                    r_long  <= w_long;
                    r_off   <= w_head[25:0];
                end else if (w_hs) begin
                    r_valid <= 1'b0;
                end
                if (w_hs && (r_op == OP_HALT)) r_halted <= 1'b1;
            end
        end
    end

    assign oIssueValid = r_valid;
    assign oOpcode     = r_op;
    assign oAddrRead0  = r_ar0;
    assign oEnRead0    = r_er0;
    assign oAddrRead1  = r_ar1;
    assign oEnRead1    = r_er1;
    assign oAddrWrite  = r_aw;
    assign oEnWrite    = r_ew;
    assign oLongOp     = r_long;
    assign oOffset     = r_off;
    assign oCount      = r_count;
    assign oHalted     = r_halted;

endmodule
